// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/load-store arbiter for the single memory port (optional timeout: MEM_ARB_TIMEOUT_EN)
module mem_port_arbiter #(
  parameter int unsigned MAX_DATA_STREAK = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic        i_err,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_ack,
  output logic        d_err,
  output logic [31:0] d_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        fault_valid,
  output logic [31:0] fault_cause,
  output logic [31:0] fault_addr
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, ERR_I} state_t;

  state_t      state, state_next;
  logic [31:0] streak;
  logic        fault_valid_q;
  logic [31:0] fault_cause_q, fault_addr_q;
  logic        busy, grant_d, grant_i, fetch_misaligned, timeout_hit, done;

  assign busy             = (state == BUSY_I) || (state == BUSY_D);
  // Data has priority unless a waiting fetch has already been passed over MAX_DATA_STREAK times.
  assign grant_d          = d_req && !(i_req && (MAX_DATA_STREAK != 0) && (streak >= MAX_DATA_STREAK));
  assign grant_i          = i_req && !grant_d;
  assign fetch_misaligned = (i_addr[1:0] != 2'b00);
  assign done             = busy && (mem_ack || timeout_hit);

`ifdef MEM_ARB_TIMEOUT_EN
  logic [31:0] wait_cnt;

  // A real mem_ack in the last allowed cycle still completes normally.
  assign timeout_hit = busy && !mem_ack && (wait_cnt == TIMEOUT_CYCLES - 1);

  // Count busy cycles without mem_ack; restart on every grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if ((state == IDLE) && (grant_d || grant_i)) begin
      wait_cnt <= '0;
    end else if (busy && !mem_ack) begin
      wait_cnt <= wait_cnt + 32'd1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
  assign timeout_hit    = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: arbitrate in IDLE, leave BUSY on completion, ERR_I lasts one cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (grant_d) begin
          state_next = BUSY_D;
        end else if (grant_i) begin
          state_next = fetch_misaligned ? ERR_I : BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (done) begin
          state_next = IDLE;
        end
      end
      ERR_I:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Requester responses; acks are suppressed in a reset cycle so a late mem_ack is dropped.
  always_comb begin
    i_ack = 1'b0;
    i_err = 1'b0;
    d_ack = 1'b0;
    d_err = 1'b0;
    if (!rst) begin
      case (state)
        BUSY_I: begin
          i_ack = mem_ack || timeout_hit;
          i_err = timeout_hit;
        end
        BUSY_D: begin
          d_ack = mem_ack || timeout_hit;
          d_err = timeout_hit;
        end
        ERR_I: begin
          i_ack = 1'b1;
          i_err = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

  // Misalignment faults come from registers; a timeout fault is raised in its own cycle.
  always_comb begin
    fault_valid = fault_valid_q;
    fault_cause = fault_cause_q;
    fault_addr  = fault_addr_q;
    if (timeout_hit && !rst) begin
      fault_valid = 1'b1;
      fault_addr  = mem_addr;
      fault_cause = (state == BUSY_I) ? 32'd1 : (mem_we ? 32'd7 : 32'd5);
    end
  end

  // Launch the granted transaction, track the data streak, and drop mem_req on completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_be        <= 4'b0000;
      streak        <= '0;
      fault_valid_q <= 1'b0;
      fault_cause_q <= '0;
      fault_addr_q  <= '0;
    end else begin
      fault_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_be    <= d_be;
            if (i_req && (streak < MAX_DATA_STREAK)) begin
              streak <= streak + 32'd1;
            end
          end else if (grant_i) begin
            streak <= '0;
            if (fetch_misaligned) begin
              fault_valid_q <= 1'b1;
              fault_cause_q <= 32'd0;
              fault_addr_q  <= i_addr;
            end else begin
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= i_addr;
              mem_be   <= 4'b1111;
            end
          end
        end
        BUSY_I, BUSY_D: begin
          if (done) begin
            mem_req <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
